scpad_sram_arb: RTL

- Parametrised, registered arbiter that grants scratchpad SRAM/crossbar reservation to one of NUM_REQ requesters, e.g. backend, frontend VC and frontend SA.
- Replaces the fixed three-way BE>VC>SA priority with these features:
  - runtime-selectable fixed-priority or round-robin mode;
  - multi-beat locked grants with a bounded hold;
  - starvation aging.
- Sits between requesting units and the SRAM control / crossbar. It forwards the winner's crossbar descriptor.

---
 rtl/spad_types_pkg.sv | 18 +
 rtl/scpad_sram_arb_if.sv | 40 ++++
 rtl/scpad_sram_arb_age_ctr.sv | 46 ++++
 rtl/scpad_sram_arb.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/spad_types_pkg.sv
// spad_types_pkg
//   Shared types and default constants for the scratchpad SRAM arbiter.
//   - arb_mode_e      : arbitration policy selected at runtime
//   - SCPAD_*         : default parameter values for scpad_sram_arb
//   - REQ_*           : requester index assignment (index 0 = highest priority)
package spad_types_pkg;

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

  localparam int SCPAD_NUM_REQ  = 3;
  localparam int SCPAD_AGE_MAX  = 15;
  localparam int SCPAD_MAX_LOCK = 8;

  localparam int REQ_BE = 0;
  localparam int REQ_VC = 1;
  localparam int REQ_SA = 2;

endpackage

// File: rtl/scpad_sram_arb_if.sv
// scpad_sram_arb_if
//   Request/grant bundle between the scratchpad requesters and the arbiter.
//   Requester side (master) drives:
//     mode_i   : 0 fixed priority, 1 round-robin
//     req_i    : per-requester request
//     lock_i   : per-requester request to keep the grant
//     desc_i   : packed descriptors, slice i belongs to requester i
//   Arbiter side (slave) drives:
//     gnt_o, gnt_valid_o, gnt_idx_o : registered one-hot grant, any-grant, index
//     desc_o                        : descriptor of the current grantee (0 if none)
//     starve_o                      : per-requester starved flag
interface scpad_sram_arb_if
  import spad_types_pkg::*;
#(
  parameter int NUM_REQ = SCPAD_NUM_REQ,
  parameter int DESC_W  = 24
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic                      mode_i;
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ-1:0]        lock_i;
  logic [NUM_REQ*DESC_W-1:0] desc_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic                      gnt_valid_o;
  logic [IDX_W-1:0]          gnt_idx_o;
  logic [DESC_W-1:0]         desc_o;
  logic [NUM_REQ-1:0]        starve_o;

  modport master (
    output mode_i, req_i, lock_i, desc_i,
    input  gnt_o, gnt_valid_o, gnt_idx_o, desc_o, starve_o
  );

  modport slave (
    input  mode_i, req_i, lock_i, desc_i,
    output gnt_o, gnt_valid_o, gnt_idx_o, desc_o, starve_o
  );

endinterface

// File: rtl/scpad_sram_arb_age_ctr.sv
// scpad_age_ctr
//   Per-requester wait counter. Counts cycles a request waits without being
//   granted, saturating at AGE_MAX; any cycle without a request, or with a
//   grant, clears it.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     req      : requester is asking this cycle
//     clr      : requester holds the grant decided on this edge
//     starved  : counter currently at AGE_MAX (feeds winner selection)
//     starve   : starved flag registered one cycle later (drives starve_o)
module scpad_age_ctr #(
  parameter int AGE_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic clr,
  output logic starved,
  output logic starve
);
  localparam int AGE_W = $clog2(AGE_MAX + 1);

  logic [AGE_W-1:0] age_p1;

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_W'(AGE_MAX)) ? a : a + 1'b1;
  endfunction

  assign starved = (age_p1 == AGE_W'(AGE_MAX));

  // stage p1: age count and its registered starved flag
  always_ff @(posedge clk) begin
    if (rst) begin
      age_p1 <= '0;
      starve <= 1'b0;
    end else begin
      starve <= starved;
      if (!req || clr) begin
        age_p1 <= '0;
      end else begin
        age_p1 <= age_sat_inc(age_p1);
      end
    end
  end

endmodule

// File: rtl/scpad_sram_arb.sv
// scpad_sram_arb
//   Registered arbiter granting scratchpad SRAM / crossbar reservation to one
//   of NUM_REQ requesters. Fixed-priority or round-robin selection, locked
//   multi-beat grants bounded by MAX_LOCK while others wait, and starvation
//   aging that overrides either policy.
//   Ports:
//     clk  : clock
//     rst  : synchronous active-high reset
//     bus  : scpad_sram_arb_if.slave (requests, locks, descriptors in;
//            grant, index, descriptor, starved flags out)
module scpad_sram_arb
  import spad_types_pkg::*;
#(
  parameter int NUM_REQ  = SCPAD_NUM_REQ,
  parameter int DESC_W   = 24,
  parameter int AGE_MAX  = SCPAD_AGE_MAX,
  parameter int MAX_LOCK = SCPAD_MAX_LOCK
) (
  input  logic               clk,
  input  logic               rst,
  scpad_sram_arb_if.slave    bus
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_LOCK + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]         state_p0, state_p1;
  logic [NUM_REQ-1:0] gnt_p0, gnt_p1;
  logic [IDX_W-1:0]   idx_p0, idx_p1;
  logic [IDX_W-1:0]   rr_ptr_p0, rr_ptr_p1;
  logic [BEAT_W-1:0]  beat_p0, beat_p1;

  logic [NUM_REQ-1:0] starved;
  logic [NUM_REQ-1:0] starve_p1;

  logic               req_w, lock_w, others, locked, hold, cut;
  logic [NUM_REQ-1:0] cand, starved_cand, pick;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [DESC_W-1:0]  desc_mux;

  function automatic logic [BEAT_W-1:0] beat_sat_inc(input logic [BEAT_W-1:0] b);
    return (b >= BEAT_W'(MAX_LOCK)) ? b : b + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] w);
    return (w == IDX_W'(NUM_REQ - 1)) ? '0 : w + 1'b1;
  endfunction

  // Current grantee status; gnt_p1 is one-hot or zero so a masked OR selects it.
  assign req_w  = |(bus.req_i & gnt_p1);
  assign lock_w = |(bus.lock_i & gnt_p1);
  assign others = |(bus.req_i & ~gnt_p1);
  assign locked = (state_p1 == ST_GRANT) && req_w && lock_w;
  assign hold   = locked && (!others || (beat_p1 < BEAT_W'(MAX_LOCK)));
  // A hold cut short by MAX_LOCK must hand over, so the grantee sits out.
  assign cut    = locked && others && (beat_p1 >= BEAT_W'(MAX_LOCK));

  // Winner selection: starved first (lowest index), then fixed or round-robin.
  always_comb begin
    int j;
    cand         = bus.req_i & (cut ? ~gnt_p1 : {NUM_REQ{1'b1}});
    starved_cand = cand & starved;
    pick         = (|starved_cand) ? starved_cand : cand;
    win_found    = 1'b0;
    win_idx      = '0;
    j            = 0;
    if ((|starved_cand) || (arb_mode_e'(bus.mode_i) == ARB_FIXED)) begin
      // Scan downward so the last hit is the lowest index.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (pick[i]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = int'(rr_ptr_p1) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        if (!win_found && cand[j]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(j);
        end
      end
    end
  end

  always_comb begin
    state_p0  = ST_IDLE;
    gnt_p0    = '0;
    idx_p0    = '0;
    beat_p0   = '0;
    rr_ptr_p0 = rr_ptr_p1;
    if (hold) begin
      state_p0 = ST_GRANT;
      gnt_p0   = gnt_p1;
      idx_p0   = idx_p1;
      beat_p0  = beat_sat_inc(beat_p1);
    end else if (win_found) begin
      state_p0  = ST_GRANT;
      for (int i = 0; i < NUM_REQ; i++) begin
        gnt_p0[i] = (win_idx == IDX_W'(i));
      end
      idx_p0    = win_idx;
      beat_p0   = BEAT_W'(1);
      rr_ptr_p0 = ptr_after(win_idx);
    end
  end

  // stage p1: grant state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1  <= ST_IDLE;
      gnt_p1    <= '0;
      idx_p1    <= '0;
      rr_ptr_p1 <= '0;
      beat_p1   <= '0;
    end else begin
      state_p1  <= state_p0;
      gnt_p1    <= gnt_p0;
      idx_p1    <= idx_p0;
      rr_ptr_p1 <= rr_ptr_p0;
      beat_p1   <= beat_p0;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_age
    scpad_age_ctr #(
      .AGE_MAX (AGE_MAX)
    ) u_age (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.req_i[i]),
      .clr     (gnt_p0[i]),
      .starved (starved[i]),
      .starve  (starve_p1[i])
    );
  end

  // Descriptor follows the registered grant combinationally.
  always_comb begin
    desc_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_p1[i]) desc_mux = bus.desc_i[i*DESC_W +: DESC_W];
    end
  end

  assign bus.gnt_o       = gnt_p1;
  assign bus.gnt_valid_o = |gnt_p1;
  assign bus.gnt_idx_o   = idx_p1;
  assign bus.desc_o      = desc_mux;
  assign bus.starve_o    = starve_p1;

endmodule
